// File: rtl/atm_pkg.sv
// Shared encodings and helpers for the ATM display-mux sequencer.
package atm_pkg;
  localparam int SEL_W  = 4;
  localparam int NSLOTS = 16;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SHOW = 2'd1,
    DONE = 2'd2
  } state_t;

  // Window lengths above the number of mux inputs collapse to a full sweep.
  function automatic logic [4:0] clamp_count(input logic [4:0] c);
    return (c > 5'(NSLOTS)) ? 5'(NSLOTS) : c;
  endfunction
endpackage

// File: rtl/scan_dwell_timer.sv
// Loadable down-counter that times how long each mux slot is held.
module scan_dwell_timer #(
  parameter int W = 2
) (
  input  logic         Clock,
  input  logic         Resetn,
  input  logic         Load,
  input  logic [W-1:0] LoadVal,
  output logic         Zero
);
  logic [W-1:0] cnt;

  always_ff @(posedge Clock or negedge Resetn) begin
    if (!Resetn)
      cnt <= '0;
    else if (Load)
      cnt <= LoadVal;
    else if (cnt != '0)
      cnt <= cnt - W'(1);
  end

  assign Zero = (cnt == '0);
endmodule

// File: rtl/mux_scan_ctrl.sv
// Walks the 16-to-1 display mux select through a window of slots, holding each
// for DWELL cycles; all outputs are registered.
module mux_scan_ctrl
  import atm_pkg::*;
#(
  parameter int DWELL = 4
) (
  input  logic       Clock,
  input  logic       Resetn,
  input  logic       Start,
  input  logic       Stop,
  input  logic [3:0] First,
  input  logic [4:0] Count,
  input  logic       Repeat,
  output logic       S3,
  output logic       S2,
  output logic       S1,
  output logic       S0,
  output logic       Valid,
  output logic       Busy,
  output logic       Done
);
  localparam int DW_W = (DWELL > 1) ? $clog2(DWELL) : 1;
  localparam logic [DW_W-1:0] DW_RELOAD = DW_W'(DWELL - 1);

  state_t state, state_nxt;
  logic [SEL_W-1:0] sel, sel_nxt;
  logic [SEL_W-1:0] rem, rem_nxt;
  logic [SEL_W-1:0] first_q, first_nxt;
  logic [SEL_W-1:0] last_q, last_nxt;
  logic [4:0]       count_cl;
  logic [SEL_W-1:0] cnt_m1;
  logic             load;
  logic             zero;

  assign count_cl = clamp_count(Count);
  assign cnt_m1   = SEL_W'(count_cl - 5'd1);

  scan_dwell_timer #(.W(DW_W)) u_dwell (
    .Clock   (Clock),
    .Resetn  (Resetn),
    .Load    (load),
    .LoadVal (DW_RELOAD),
    .Zero    (zero)
  );

  always_comb begin
    state_nxt = state;
    sel_nxt   = sel;
    rem_nxt   = rem;
    first_nxt = first_q;
    last_nxt  = last_q;
    load      = 1'b0;
    case (state)
      IDLE: begin
        if (Start && !Stop) begin
          if (count_cl == 5'd0) begin
            state_nxt = DONE;
          end else begin
            state_nxt = SHOW;
            sel_nxt   = First;
            first_nxt = First;
            last_nxt  = cnt_m1;
            rem_nxt   = cnt_m1;
            load      = 1'b1;
          end
        end
      end
      SHOW: begin
        // Stop beats every dwell/advance decision in the same cycle.
        if (Stop) begin
          state_nxt = IDLE;
        end else if (zero) begin
          if (rem != '0) begin
            sel_nxt = sel + SEL_W'(1);
            rem_nxt = rem - SEL_W'(1);
            load    = 1'b1;
          end else if (Repeat) begin
            sel_nxt = first_q;
            rem_nxt = last_q;
            load    = 1'b1;
          end else begin
            state_nxt = DONE;
          end
        end
      end
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge Clock or negedge Resetn) begin
    if (!Resetn) begin
      state   <= IDLE;
      sel     <= '0;
      rem     <= '0;
      first_q <= '0;
      last_q  <= '0;
      Valid   <= 1'b0;
      Busy    <= 1'b0;
      Done    <= 1'b0;
    end else begin
      state   <= state_nxt;
      sel     <= sel_nxt;
      rem     <= rem_nxt;
      first_q <= first_nxt;
      last_q  <= last_nxt;
      Valid   <= (state_nxt == SHOW);
      Busy    <= (state_nxt != IDLE);
      Done    <= (state_nxt == DONE);
    end
  end

  assign {S3, S2, S1, S0} = sel;
endmodule

// File: tb/tb_mux_scan_ctrl.sv
// Directed scoreboard bench for mux_scan_ctrl with DWELL=2 and DWELL=1 instances.
module tb_mux_scan_ctrl;
  logic       Clock;
  logic       Resetn;
  logic       start_a, start_b, Stop, Repeat;
  logic [3:0] First;
  logic [4:0] Count;

  logic s3a, s2a, s1a, s0a, va, ba, da;
  logic s3b, s2b, s1b, s0b, vb, bb, db;
  logic [6:0] obs_a, obs_b;
  logic [7:0] f_a;

  typedef struct {
    int          k;
    logic [6:0]  exp;
    logic        fen;
    logic [7:0]  f;
    string       tag;
  } exp_t;

  exp_t sbq[$];
  int vectors = 0;
  int miscompares = 0;

  mux_scan_ctrl #(.DWELL(2)) dut_a (
    .Clock(Clock), .Resetn(Resetn), .Start(start_a), .Stop(Stop),
    .First(First), .Count(Count), .Repeat(Repeat),
    .S3(s3a), .S2(s2a), .S1(s1a), .S0(s0a),
    .Valid(va), .Busy(ba), .Done(da)
  );

  mux_scan_ctrl #(.DWELL(1)) dut_b (
    .Clock(Clock), .Resetn(Resetn), .Start(start_b), .Stop(Stop),
    .First(First), .Count(Count), .Repeat(Repeat),
    .S3(s3b), .S2(s2b), .S1(s1b), .S0(s0b),
    .Valid(vb), .Busy(bb), .Done(db)
  );

  assign obs_a = {s3a, s2a, s1a, s0a, va, ba, da};
  assign obs_b = {s3b, s2b, s1b, s0b, vb, bb, db};
  // Stand-in for the integration-level Mux16to1_8b with W_i = 8'hA0 + i.
  assign f_a = 8'hA0 + {4'd0, s3a, s2a, s1a, s0a};

  initial Clock = 1'b0;
  always #5 Clock = ~Clock;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic push(input int k, input int s, input logic v, input logic b,
                      input logic d, input string tag,
                      input logic fen = 1'b0, input logic [7:0] f = 8'h00);
    exp_t e;
    e.k   = k;
    e.exp = {4'(s), v, b, d};
    e.fen = fen;
    e.f   = f;
    e.tag = tag;
    sbq.push_back(e);
  endtask

  task automatic check_all();
    exp_t e;
    logic [6:0] o;
    while (sbq.size() > 0) begin
      e = sbq.pop_front();
      o = (e.k == 0) ? obs_a : obs_b;
      vectors++;
      assert (o === e.exp) else begin
        miscompares++;
        $error("FAIL %s: observed sel=%0d v,b,d=%b required sel=%0d v,b,d=%b",
               e.tag, o[6:3], o[2:0], e.exp[6:3], e.exp[2:0]);
      end
      if (e.fen) begin
        vectors++;
        assert (f_a === e.f) else begin
          miscompares++;
          $error("FAIL %s_F: observed F=%h required F=%h", e.tag, f_a, e.f);
        end
      end
    end
  endtask

  task automatic tick();
    @(posedge Clock);
    #1;
    check_all();
  endtask

  initial begin
    int s2[8]  = '{14, 14, 15, 15, 0, 0, 1, 1};
    int s5[4]  = '{2, 2, 3, 3};
    int s6[6]  = '{5, 5, 6, 6, 7, 7};
    logic [7:0] f6[6] = '{8'hA5, 8'hA5, 8'hA6, 8'hA6, 8'hA7, 8'hA7};

    Resetn = 1'b0; start_a = 1'b0; start_b = 1'b0; Stop = 1'b0;
    Repeat = 1'b0; First = 4'd0; Count = 5'd0;

    push(0, 0, 0, 0, 0, "rst_a");
    push(1, 0, 0, 0, 0, "rst_b");
    tick();
    Resetn = 1'b1;
    push(0, 0, 0, 0, 0, "rst_rel_a");
    tick();

    // Non-looping window across the 15 -> 0 wrap, DWELL=2.
    First = 4'd14; Count = 5'd4; Repeat = 1'b0; start_a = 1'b1;
    for (int i = 0; i < 8; i++) begin
      push(0, s2[i], 1, 1, 0, "t2_show");
      tick();
      start_a = 1'b0;
    end
    push(0, 1, 0, 1, 1, "t2_done");
    tick();
    push(0, 1, 0, 0, 0, "t2_idle");
    tick();
    push(0, 1, 0, 0, 0, "t2_idle2");
    tick();

    // Looping window on DWELL=1, aborted by Stop.
    First = 4'd3; Count = 5'd2; Repeat = 1'b1; start_b = 1'b1;
    for (int i = 0; i < 6; i++) begin
      push(1, (i % 2 == 1) ? 4 : 3, 1, 1, 0, "t3_loop");
      tick();
      start_b = 1'b0;
    end
    Stop = 1'b1;
    push(1, 4, 0, 0, 0, "t3_stop");
    push(0, 1, 0, 0, 0, "t3_stop_a_idle");
    tick();
    Stop = 1'b0; Repeat = 1'b0;
    for (int i = 0; i < 3; i++) begin
      push(1, 4, 0, 0, 0, "t3_nodone");
      tick();
    end

    // Count=0 goes straight to DONE without Valid.
    First = 4'd7; Count = 5'd0; start_a = 1'b1;
    push(0, 1, 0, 1, 1, "t4_cnt0_done");
    tick();
    start_a = 1'b0;
    push(0, 1, 0, 0, 0, "t4_cnt0_idle");
    tick();

    // Count=20 clamps to a full 16-slot sweep.
    First = 4'd0; Count = 5'd20; start_b = 1'b1;
    for (int i = 0; i < 16; i++) begin
      push(1, i, 1, 1, 0, "t4_clamp");
      tick();
      start_b = 1'b0;
    end
    push(1, 15, 0, 1, 1, "t4_clamp_done");
    tick();
    push(1, 15, 0, 0, 0, "t4_clamp_idle");
    tick();

    // Start together with Stop in IDLE does nothing.
    First = 4'd2; Count = 5'd2; start_a = 1'b1; Stop = 1'b1;
    for (int i = 0; i < 2; i++) begin
      push(0, 1, 0, 0, 0, "t5_startstop");
      tick();
    end
    Stop = 1'b0; start_a = 1'b0;
    tick();

    // Start held and inputs changed mid-window leave the window unchanged.
    start_a = 1'b1;
    for (int i = 0; i < 4; i++) begin
      push(0, s5[i], 1, 1, 0, "t5_restart");
      tick();
      First = 4'd9; Count = 5'd16;
    end
    start_a = 1'b0;
    push(0, 3, 0, 1, 1, "t5_done");
    tick();
    push(0, 3, 0, 0, 0, "t5_idle");
    tick();

    // Asynchronous reset in the middle of a window.
    First = 4'd5; Count = 5'd3; start_a = 1'b1;
    push(0, 5, 1, 1, 0, "t1_show");
    tick();
    start_a = 1'b0;
    push(0, 5, 1, 1, 0, "t1_show2");
    tick();
    Resetn = 1'b0;
    #2;
    push(0, 0, 0, 0, 0, "t1_async_rst");
    check_all();
    push(0, 0, 0, 0, 0, "t1_rst_held");
    tick();
    Resetn = 1'b1;
    for (int i = 0; i < 3; i++) begin
      push(0, 0, 0, 0, 0, "t1_after_rel");
      tick();
    end

    // Integration view: mux data follows the select while Valid.
    First = 4'd5; Count = 5'd3; Repeat = 1'b0; start_a = 1'b1;
    for (int i = 0; i < 6; i++) begin
      push(0, s6[i], 1, 1, 0, "t6_mux", 1'b1, f6[i]);
      tick();
      start_a = 1'b0;
    end
    push(0, 7, 0, 1, 1, "t6_done");
    tick();
    push(0, 7, 0, 0, 0, "t6_idle");
    tick();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
